// File: rtl/ppi_pkg.sv
// ppi_pkg: shared constants for the ppi_sync parallel port block.
//   - control-word bit offsets, counted down from the MSB of the data word
//   - status flag ordering used to build the control/status read word
//   - helper returning the control/status register address
package ppi_pkg;

    // Control word bit offsets below the MSB (bit WIDTH-1-<ofs>)
    localparam int MODESET_OFS = 0;
    localparam int MODE1_OFS   = 1;
    localparam int INTE_OFS    = 2;

    // Status flags, packed MSB-first at the top of the status word
    localparam int STAT_NFLAGS = 7;
    localparam int STAT_ONE    = 6;
    localparam int STAT_MODE1  = 5;
    localparam int STAT_INTE   = 4;
    localparam int STAT_OVR    = 3;
    localparam int STAT_IBF    = 2;
    localparam int STAT_OBF    = 1;
    localparam int STAT_INTR   = 0;

    // Control/status register sits directly after the last port
    function automatic int ctrl_addr(input int nports);
        return nports;
    endfunction

endpackage

// File: rtl/ppi_sync_edge.sv
// ppi_sync_edge: two-flop synchroniser plus falling-edge detector.
//   clk, reset_n : clock and asynchronous active-low reset
//   async_i [W]  : asynchronous input(s)
//   sync_o  [W]  : synchronised level
//   fall_o  [W]  : one-cycle pulse on a synchronised 1->0 transition
// RST_VAL should match the idle level of the input so that leaving reset
// does not fabricate an edge.
module ppi_sync_edge #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] sync_o,
    output logic [W-1:0] fall_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;
    logic [W-1:0] prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ppi_sync.sv
// ppi_sync: clocked NPORTS x WIDTH programmable parallel interface.
//   clk, reset_n        : clock, asynchronous active-low reset
//   cs, rd, wr, addr    : CPU strobes; addr < NPORTS is a port, NPORTS is ctrl
//   wdata / rdata       : write data / registered read data
//   rvalid              : one-cycle pulse the cycle after an accepted read
//   port_in/out/oe      : pad input, output value and output enable vectors
//   stb_n, ack_n        : mode-1 handshake inputs (asynchronous)
//   ibf, obf_n, intr    : mode-1 handshake status outputs
module ppi_sync
    import ppi_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NPORTS = 3,
    parameter int ADDR_W = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cs,
    input  logic                    rd,
    input  logic                    wr,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic                    rvalid,
    input  logic [NPORTS*WIDTH-1:0] port_in,
    output logic [NPORTS*WIDTH-1:0] port_out,
    output logic [NPORTS*WIDTH-1:0] port_oe,
    input  logic                    stb_n,
    input  logic                    ack_n,
    output logic                    ibf,
    output logic                    obf_n,
    output logic                    intr
);

    localparam int CTRL_ADDR   = ctrl_addr(NPORTS);
    localparam int MODESET_BIT = WIDTH - 1 - MODESET_OFS;
    localparam int MODE1_BIT   = WIDTH - 1 - MODE1_OFS;
    localparam int INTE_BIT    = WIDTH - 1 - INTE_OFS;

    logic [NPORTS*WIDTH-1:0] pin_sync;
    logic [NPORTS*WIDTH-1:0] pin_fall_unused;
    logic                    stb_lvl_unused, stb_fall;
    logic                    ack_lvl_unused, ack_fall;

    ppi_sync_edge #(.W(NPORTS*WIDTH), .RST_VAL('0)) u_pin_sync (
        .clk(clk), .reset_n(reset_n), .async_i(port_in),
        .sync_o(pin_sync), .fall_o(pin_fall_unused)
    );
    ppi_sync_edge #(.W(1), .RST_VAL(1'b1)) u_stb_sync (
        .clk(clk), .reset_n(reset_n), .async_i(stb_n),
        .sync_o(stb_lvl_unused), .fall_o(stb_fall)
    );
    ppi_sync_edge #(.W(1), .RST_VAL(1'b1)) u_ack_sync (
        .clk(clk), .reset_n(reset_n), .async_i(ack_n),
        .sync_o(ack_lvl_unused), .fall_o(ack_fall)
    );

    logic [NPORTS-1:0] dir_q, dir_d;
    logic [WIDTH-1:0]  out_q [NPORTS];
    logic [WIDTH-1:0]  out_d [NPORTS];
    logic [WIDTH-1:0]  latch_q, latch_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic mode1_q, mode1_d, inte_q, inte_d, ovr_q, ovr_d;
    logic ibf_q, ibf_d, obf_n_q, obf_n_d, intr_q, intr_d;
    logic rvalid_q, rvalid_d;

    logic wr_acc, rd_acc, ctrl_sel, rd_p0;
    assign wr_acc   = cs & wr;
    assign rd_acc   = cs & rd & ~wr;   // a simultaneous write takes precedence
    assign ctrl_sel = (addr == ADDR_W'(CTRL_ADDR));
    assign rd_p0    = rd_acc & (addr == '0);

    // Status word: flags from the MSB down, dir in the low bits. When WIDTH
    // is too narrow for all flags, dir keeps its bits and the lowest flags
    // are dropped (they remain visible on the ibf/obf_n/intr pins).
    logic [STAT_NFLAGS-1:0]       flags;
    logic [WIDTH+STAT_NFLAGS-1:0] stat_wide;
    logic [WIDTH-1:0]             status;
    always_comb begin
        flags             = '0;
        flags[STAT_ONE]   = 1'b1;
        flags[STAT_MODE1] = mode1_q;
        flags[STAT_INTE]  = inte_q;
        flags[STAT_OVR]   = ovr_q;
        flags[STAT_IBF]   = ibf_q;
        flags[STAT_OBF]   = ~obf_n_q;
        flags[STAT_INTR]  = intr_q;
        stat_wide         = {flags, {WIDTH{1'b0}}};
        status            = {stat_wide[WIDTH+STAT_NFLAGS-1 -: WIDTH-NPORTS], dir_q};
    end

    always_comb begin
        dir_d    = dir_q;
        mode1_d  = mode1_q;
        inte_d   = inte_q;
        ovr_d    = ovr_q;
        ibf_d    = ibf_q;
        obf_n_d  = obf_n_q;
        intr_d   = intr_q;
        latch_d  = latch_q;
        rdata_d  = rdata_q;
        rvalid_d = rd_acc;
        for (int i = 0; i < NPORTS; i++) out_d[i] = out_q[i];

        if (rd_acc) begin
            rdata_d = '0;
            if (ctrl_sel) rdata_d = status;
            for (int i = 0; i < NPORTS; i++) begin
                if (addr == ADDR_W'(i)) begin
                    if (dir_q[i])              rdata_d = out_q[i];
                    else if (i == 0 && mode1_q) rdata_d = latch_q;
                    else                        rdata_d = pin_sync[i*WIDTH +: WIDTH];
                end
            end
        end

        if (mode1_q && !dir_q[0]) begin
            // A read in the same cycle frees the buffer, so a concurrent
            // strobe latches fresh data instead of flagging an overrun.
            if (stb_fall) begin
                if (ibf_q && !rd_p0) begin
                    ovr_d = 1'b1;
                end else begin
                    latch_d = pin_sync[WIDTH-1:0];
                    ibf_d   = 1'b1;
                end
            end else if (rd_p0) begin
                ibf_d = 1'b0;
            end
            intr_d = inte_q & ibf_d;
        end else if (mode1_q) begin
            if (ack_fall && !obf_n_q) begin
                obf_n_d = 1'b1;
                intr_d  = inte_q;
            end
        end else begin
            ibf_d   = 1'b0;
            obf_n_d = 1'b1;
            intr_d  = 1'b0;
        end

        // Writes are evaluated last so a port-0 write overrides a same-cycle ack
        if (wr_acc) begin
            for (int i = 0; i < NPORTS; i++) begin
                if (addr == ADDR_W'(i)) out_d[i] = wdata;
            end
            if (addr == '0 && mode1_q && dir_q[0]) begin
                obf_n_d = 1'b0;
                intr_d  = 1'b0;
            end
            if (ctrl_sel) begin
                if (wdata[MODESET_BIT]) begin
                    dir_d   = wdata[NPORTS-1:0];
                    mode1_d = wdata[MODE1_BIT];
                    inte_d  = wdata[INTE_BIT];
                    for (int i = 0; i < NPORTS; i++) out_d[i] = '0;
                    ibf_d   = 1'b0;
                    ovr_d   = 1'b0;
                    intr_d  = 1'b0;
                    obf_n_d = 1'b1;
                end else begin
                    // Bit index wdata[3:1]; indices beyond WIDTH match nothing
                    for (int b = 0; b < WIDTH; b++) begin
                        if (int'(wdata[3:1]) == b) out_d[NPORTS-1][b] = wdata[0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_q    <= '0;
            mode1_q  <= 1'b0;
            inte_q   <= 1'b0;
            ovr_q    <= 1'b0;
            ibf_q    <= 1'b0;
            obf_n_q  <= 1'b1;
            intr_q   <= 1'b0;
            latch_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            for (int i = 0; i < NPORTS; i++) out_q[i] <= '0;
        end else begin
            dir_q    <= dir_d;
            mode1_q  <= mode1_d;
            inte_q   <= inte_d;
            ovr_q    <= ovr_d;
            ibf_q    <= ibf_d;
            obf_n_q  <= obf_n_d;
            intr_q   <= intr_d;
            latch_q  <= latch_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            for (int i = 0; i < NPORTS; i++) out_q[i] <= out_d[i];
        end
    end

    for (genvar g = 0; g < NPORTS; g++) begin : g_port
        assign port_out[g*WIDTH +: WIDTH] = out_q[g];
        assign port_oe[g*WIDTH +: WIDTH]  = {WIDTH{dir_q[g]}};
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign ibf    = ibf_q;
    assign obf_n  = obf_n_q;
    assign intr   = intr_q;

endmodule

// File: tb/tb_ppi_sync.sv
module tb_ppi_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance: WIDTH=8, NPORTS=3
    logic        reset_n, cs, rd, wr;
    logic [1:0]  addr;
    logic [7:0]  wdata, rdata;
    logic        rvalid;
    logic [23:0] port_in, port_out, port_oe;
    logic        stb_n, ack_n, ibf, obf_n, intr;

    ppi_sync #(.WIDTH(8), .NPORTS(3), .ADDR_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .rd(rd), .wr(wr),
        .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
        .port_in(port_in), .port_out(port_out), .port_oe(port_oe),
        .stb_n(stb_n), .ack_n(ack_n), .ibf(ibf), .obf_n(obf_n), .intr(intr)
    );

    // Narrow instance: WIDTH=5, NPORTS=2 (BSR index boundary)
    logic        cs5, rd5, wr5, stb5, ack5;
    logic [1:0]  addr5;
    logic [4:0]  wdata5, rdata5;
    logic        rvalid5, ibf5, obf_n5, intr5;
    logic [9:0]  pin5, pout5, poe5;

    ppi_sync #(.WIDTH(5), .NPORTS(2), .ADDR_W(2)) dut5 (
        .clk(clk), .reset_n(reset_n), .cs(cs5), .rd(rd5), .wr(wr5),
        .addr(addr5), .wdata(wdata5), .rdata(rdata5), .rvalid(rvalid5),
        .port_in(pin5), .port_out(pout5), .port_oe(poe5),
        .stb_n(stb5), .ack_n(ack5), .ibf(ibf5), .obf_n(obf_n5), .intr(intr5)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
        string      name;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Read monitor: every rvalid pops one expected response
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rvalid === 1'b1) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_rvalid: got rdata=%h, required no response", rdata);
                end else begin
                    e = sbq.pop_front();
                    if (rdata !== e.data || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL %s: got rdata=%h at cycle %0d, required %h at cycle %0d",
                                 e.name, rdata, cyc, e.data, e.cyc);
                    end
                end
            end
        end
    end

    task automatic do_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] a, input logic [7:0] exp, input string nm);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        sbq.push_back('{exp, cyc + 1, nm});
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic do_write5(input logic [1:0] a, input logic [4:0] d);
        @(negedge clk);
        cs5 = 1'b1; wr5 = 1'b1; addr5 = a; wdata5 = d;
        @(negedge clk);
        cs5 = 1'b0; wr5 = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_stb();
        @(negedge clk); stb_n = 1'b0;
        repeat (2) @(negedge clk);
        stb_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_ack();
        @(negedge clk); ack_n = 1'b0;
        repeat (2) @(negedge clk);
        ack_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; cs = 0; rd = 0; wr = 0; addr = '0; wdata = '0;
        port_in = '0; stb_n = 1'b1; ack_n = 1'b1;
        cs5 = 0; rd5 = 0; wr5 = 0; addr5 = '0; wdata5 = '0;
        pin5 = '0; stb5 = 1'b1; ack5 = 1'b1;

        // Reset state
        wait_cyc(2);
        check("rst_oe", port_oe, 24'h0);
        check("rst_out", port_out, 24'h0);
        check("rst_ibf", ibf, 1'b0);
        check("rst_obf_n", obf_n, 1'b1);
        check("rst_intr", intr, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_out5", pout5, 10'h0);
        reset_n = 1'b1;
        wait_cyc(2);

        // Mode set: ports 0,1 output, port 2 input
        do_write(2'd3, 8'h83);
        check("ms83_oe", port_oe, 24'h00FFFF);
        check("ms83_out", port_out, 24'h0);
        do_read(2'd3, 8'h83, "ctrl_rd_83");
        do_read(2'd0, 8'h00, "p0_out_reg");

        do_write(2'd1, 8'hA5);
        check("p1_wr_out", port_out, 24'h00A500);
        do_read(2'd1, 8'hA5, "p1_rd_reg");

        // Input reads of synchronised pads
        port_in = 24'hC3003C;
        do_write(2'd3, 8'h82);
        check("ms82_oe", port_oe, 24'h00FF00);
        check("ms82_clr", port_out, 24'h0);
        wait_cyc(3);
        do_read(2'd0, 8'h3C, "p0_pin");
        do_read(2'd2, 8'hC3, "p2_pin");
        do_read(2'd1, 8'h00, "p1_cleared");

        // BSR on last port, then write to an input port
        do_write(2'd3, 8'h07);
        check("bsr_set3", port_out, 24'h080000);
        do_write(2'd3, 8'h06);
        check("bsr_clr3", port_out, 24'h000000);
        do_write(2'd2, 8'h5C);
        check("p2_wr_undriven_out", port_out, 24'h5C0000);
        check("p2_wr_undriven_oe", port_oe, 24'h00FF00);
        do_read(2'd3, 8'h82, "ctrl_rd_82");
        do_read(2'd2, 8'hC3, "p2_pin_after_wr");

        // BSR index boundary on WIDTH=5
        do_write5(2'd2, 5'b00101);
        check("bsr5_idx2", pout5, 10'h080);
        do_write5(2'd2, 5'b01111);
        check("bsr5_idx7_ign", pout5, 10'h080);
        do_write5(2'd2, 5'b01011);
        check("bsr5_idx5_ign", pout5, 10'h080);
        do_write5(2'd2, 5'b01001);
        check("bsr5_idx4", pout5, 10'h280);

        // Mode 1 input
        do_write(2'd3, 8'hE0);
        check("m1i_oe", port_oe, 24'h0);
        check("m1i_out", port_out, 24'h0);
        check("m1i_obf_n", obf_n, 1'b1);
        port_in = 24'h00005A;
        wait_cyc(3);
        pulse_stb();
        check("m1i_ibf", ibf, 1'b1);
        check("m1i_intr", intr, 1'b1);
        do_read(2'd3, 8'hE8, "ctrl_rd_ibf");
        port_in = 24'h000011;
        wait_cyc(3);
        pulse_stb();
        check("m1i_ibf_ovr", ibf, 1'b1);
        do_read(2'd3, 8'hF8, "ctrl_rd_ovr");
        do_read(2'd0, 8'h5A, "p0_latch");
        check("m1i_ibf_clr", ibf, 1'b0);
        check("m1i_intr_clr", intr, 1'b0);
        do_read(2'd3, 8'hF0, "ctrl_rd_ovr_sticky");
        do_read(2'd0, 8'h5A, "p0_latch_again");

        // Mode 1 output
        do_write(2'd3, 8'hE1);
        check("m1o_obf_n0", obf_n, 1'b1);
        check("m1o_oe", port_oe, 24'h0000FF);
        do_write(2'd0, 8'h77);
        check("m1o_wr_obf_n", obf_n, 1'b0);
        check("m1o_wr_intr", intr, 1'b0);
        check("m1o_wr_out", port_out[7:0], 8'h77);
        pulse_ack();
        check("m1o_ack_obf_n", obf_n, 1'b1);
        check("m1o_ack_intr", intr, 1'b1);
        do_read(2'd3, 8'hE1, "ctrl_rd_m1o");
        do_write(2'd0, 8'h33);
        check("m1o_wr2_obf_n", obf_n, 1'b0);
        // Edge pulse reaches the core in the cycle the write is sampled
        @(negedge clk); ack_n = 1'b0;
        @(negedge clk);
        do_write(2'd0, 8'h99);
        ack_n = 1'b1;
        check("m1o_race_obf_n", obf_n, 1'b0);
        check("m1o_race_intr", intr, 1'b0);
        check("m1o_race_out", port_out[7:0], 8'h99);
        wait_cyc(3);
        check("m1o_race_obf_n_late", obf_n, 1'b0);

        // Asynchronous reset in the middle of a handshake
        do_write(2'd3, 8'hE0);
        port_in = 24'h000042;
        wait_cyc(3);
        pulse_stb();
        check("pre_rst_ibf", ibf, 1'b1);
        check("pre_rst_intr", intr, 1'b1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_ibf", ibf, 1'b0);
        check("arst_intr", intr, 1'b0);
        check("arst_obf_n", obf_n, 1'b1);
        check("arst_oe", port_oe, 24'h0);
        check("arst_out", port_out, 24'h0);
        check("arst_rdata", rdata, 8'h00);
        check("arst_rvalid", rvalid, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_cyc(2);
        do_read(2'd3, 8'h80, "ctrl_rd_post_rst");

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d outstanding reads, required 0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
